// File: rtl/seg_num_fmt_if.sv
// Purpose: request/result bundle between a number source and seg_num_fmt.
// Latency: none, wires only.
// Backpressure: none; start is ignored by the formatter while busy is high.
// Ports: start/value/hex_mode/blank_lz (source -> formatter);
//        busy/done/overflow/data/enables (formatter -> source and display).
interface seg_num_fmt_if;
  logic        start;
  logic [19:0] value;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [23:0] data;
  logic [5:0]  enables;

  modport master (
    output start, value, hex_mode, blank_lz,
    input  busy, done, overflow, data, enables
  );

  modport slave (
    input  start, value, hex_mode, blank_lz,
    output busy, done, overflow, data, enables
  );
endinterface

// File: rtl/seg_num_fmt.sv
// Purpose: format a 20-bit unsigned value as six display digits (BCD via double-dabble, or hex).
// Latency: done 21 clocks after the accepting edge in decimal mode, 1 clock in hex mode.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
// Ports: clk, rst (sync, active-low); bus = seg_num_fmt_if.slave carrying the
//        request (start/value/hex_mode/blank_lz) and held result
//        (busy/done/overflow/data/enables).
module seg_num_fmt (
  input  logic          clk,
  input  logic          rst,
  seg_num_fmt_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, FMT} state_t;

  state_t      state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [19:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        hex_q, hex_d;
  logic        blank_q, blank_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;
  logic [23:0] data_q, data_d;
  logic [5:0]  enables_q, enables_d;

  logic [23:0] acc_adj;
  logic [23:0] fmt_dat;
  logic [5:0]  fmt_en;

  // Double-dabble correction: any BCD nibble >= 5 would overflow past 9 on the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 6; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Final digit image; shreg_q still holds the untouched value in hex mode.
  always_comb begin
    fmt_dat = acc_q;
    if (hex_q) begin
      fmt_dat = {4'h0, shreg_q};
    end else if (ovf_q) begin
      fmt_dat = 24'h999999;
    end
  end

  // Digit i is lit when it or any more significant digit is nonzero; digit 0 always lit.
  always_comb begin
    fmt_en = 6'b111111;
    if (blank_q) begin
      fmt_en[0] = 1'b1;
      for (int i = 1; i < 6; i++) begin
        fmt_en[i] = |(fmt_dat >> (4*i));
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    hex_d      = hex_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    data_d     = data_q;
    enables_d  = enables_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = 24'h000000;
          shreg_d = bus.value;
          cnt_d   = 5'd0;
          hex_d   = bus.hex_mode;
          blank_d = bus.blank_lz;
          ovf_d   = (bus.value > 20'd999999);
          busy_d  = 1'b1;
          state_d = bus.hex_mode ? FMT : SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) begin
          state_d = FMT;
        end
      end
      FMT: begin
        data_d     = fmt_dat;
        enables_d  = fmt_en;
        overflow_d = ovf_q && !hex_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= 24'h000000;
      shreg_q    <= 20'h00000;
      cnt_q      <= 5'd0;
      hex_q      <= 1'b0;
      blank_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= 24'h000000;
      enables_q  <= 6'b000001;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      hex_q      <= hex_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      enables_q  <= enables_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.data     = data_q;
  assign bus.enables  = enables_q;

endmodule

// File: tb/tb_seg_num_fmt.sv
// Purpose: directed self-checking bench for seg_num_fmt.
// Latency: checks done timing of 21 clocks (decimal) and 1 clock (hex).
// Backpressure: exercises start-while-busy and reset abort.
module tb_seg_num_fmt;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  seg_num_fmt_if bus();

  seg_num_fmt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; samples on negedges.
  task automatic convert(input logic [19:0] v, input logic h, input logic b,
                         output int lat, output int bcnt);
    @(negedge clk);
    bus.value    = v;
    bus.hex_mode = h;
    bus.blank_lz = b;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    while (lat < 40 && !bus.done) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.busy) bcnt++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [19:0] v, input logic h, input logic b,
                         input logic [23:0] exp_dat, input logic [5:0] exp_en,
                         input logic exp_ovf);
    int lat;
    int bcnt;
    convert(v, h, b, lat, bcnt);
    chk({tag, "_lat"},  lat, h ? 32'd1 : 32'd21);
    chk({tag, "_busy"}, bcnt, h ? 32'd1 : 32'd21);
    chk({tag, "_data"}, {8'd0, bus.data}, {8'd0, exp_dat});
    chk({tag, "_en"},   {26'd0, bus.enables}, {26'd0, exp_en});
    chk({tag, "_ovf"},  {31'd0, bus.overflow}, {31'd0, exp_ovf});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, {8'd0, bus.data}, 32'd0);
    chk({tag, "_en"},   {26'd0, bus.enables}, 32'd1);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, bus.overflow}, 32'd0);
  endtask

  initial begin
    int ndone;
    logic [23:0] seen_dat;
    n_chk = 0;
    n_err = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.value    = 20'h0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset and idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_vals("idle");

    // Decimal conversions, blanking and boundaries.
    run_vec("dec123456", 20'd123456,  1'b0, 1'b0, 24'h123456, 6'b111111, 1'b0);
    run_vec("lz42",      20'd42,      1'b0, 1'b1, 24'h000042, 6'b000011, 1'b0);
    run_vec("lz0",       20'd0,       1'b0, 1'b1, 24'h000000, 6'b000001, 1'b0);
    run_vec("lz100000",  20'd100000,  1'b0, 1'b1, 24'h100000, 6'b111111, 1'b0);
    run_vec("max_ok",    20'd999999,  1'b0, 1'b0, 24'h999999, 6'b111111, 1'b0);
    run_vec("ovf_1m",    20'd1000000, 1'b0, 1'b1, 24'h999999, 6'b111111, 1'b1);
    run_vec("ovf_fffff", 20'hFFFFF,   1'b0, 1'b0, 24'h999999, 6'b111111, 1'b1);
    run_vec("after_ovf", 20'd7,       1'b0, 1'b0, 24'h000007, 6'b111111, 1'b0);

    // Input changes without start must not disturb the held result.
    bus.value    = 20'd314;
    bus.hex_mode = 1'b1;
    bus.blank_lz = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_data", {8'd0, bus.data}, 32'h000007);
    chk("hold_en",   {26'd0, bus.enables}, 32'h3f);

    // Hex pass-through.
    run_vec("hex_abcd",  20'h0ABCD, 1'b1, 1'b1, 24'h00ABCD, 6'b001111, 1'b0);
    run_vec("hex_fffff", 20'hFFFFF, 1'b1, 1'b1, 24'h0FFFFF, 6'b011111, 1'b0);

    // Start while busy is ignored.
    @(negedge clk);
    bus.value = 20'd55; bus.hex_mode = 1'b0; bus.blank_lz = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.value = 20'd77; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    seen_dat = 24'hxxxxxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        seen_dat = bus.data;
      end
    end
    chk("overlap_ndone", ndone, 32'd1);
    chk("overlap_data", {8'd0, seen_dat}, 32'h000055);
    chk("overlap_en", {26'd0, bus.enables}, 32'h03);

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    bus.value = 20'd88; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("abort");
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_ndone", ndone, 32'd0);
    chk_reset_vals("abort_idle");

    run_vec("post_abort", 20'd9, 1'b0, 1'b1, 24'h000009, 6'b000001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
